// File: rtl/barrel_shift_8_bit_pkg.sv
// Shared widths and the bit-reversal helper for the 8-bit barrel rotator.
package barrel_shift_8_bit_pkg;

  localparam int DATA_W = 8;
  localparam int SHA_W  = 3;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = x[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/barrel_shift_8_bit_rotate_right_8.sv
// Combinational 8-bit right rotator built as a 3-stage log shifter (1, 2, 4).
module rotate_right_8
  import barrel_shift_8_bit_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [SHA_W-1:0]  amt,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] s1, s2;

  always_comb begin
    s1  = amt[0] ? {in[0],   in[7:1]} : in;
    s2  = amt[1] ? {s1[1:0], s1[7:2]} : s1;
    out = amt[2] ? {s2[3:0], s2[7:4]} : s2;
  end

endmodule

// File: rtl/barrel_shift_8_bit.sv
// Registered 8-bit rotator; left rotates reuse the right core by mirroring
// the word on the way in and out.
module barrel_shift_8_bit
  import barrel_shift_8_bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              lr,
  input  logic [SHA_W-1:0]  sha,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] core_in, core_out;
  logic [DATA_W-1:0] out_d, out_q;

  always_comb begin
    core_in = lr ? bit_rev(in) : in;
  end

  rotate_right_8 u_rot (
    .in  (core_in),
    .amt (sha),
    .out (core_out)
  );

  always_comb begin
    out_d = lr ? bit_rev(core_out) : core_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_barrel_shift_8_bit.sv
// Self-checking bench for barrel_shift_8_bit against a bit-index rotate model.
module tb_barrel_shift_8_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in  = 8'hFF;
  logic       lr  = 1'b1;
  logic [2:0] sha = 3'd3;
  logic [7:0] out;

  int n_chk = 0;
  int n_err = 0;

  barrel_shift_8_bit dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .lr  (lr),
    .sha (sha),
    .out (out)
  );

  always #5 clk = ~clk;

  // Reference: each output bit picks the input bit at a modular index.
  function automatic logic [7:0] ref_rot(input logic [7:0] x, input logic dir_l,
                                         input int k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = dir_l ? x[(i - k + 8) % 8] : x[(i + k) % 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive inputs just after an edge, then sample just after the next edge.
  task automatic apply(input logic [7:0] d, input logic l, input logic [2:0] k);
    in = d; lr = l; sha = k;
    @(posedge clk); #1;
  endtask

  logic [7:0] right_exp [8] = '{8'h81, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
  logic [7:0] left_exp  [8] = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0};

  initial begin
    logic [7:0] r, first;
    int k2;

    // Reset asserted between edges must clear out immediately.
    #2 rst = 1'b1;
    #1 chk("rst_immediate", out, 8'h00);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold", out, 8'h00);
    end
    rst = 1'b0;

    // First post-reset edge captures the live inputs.
    apply(8'hFF, 1'b1, 3'd3);
    chk("first_after_rst", out, 8'hFF);

    for (int k = 0; k < 8; k++) begin
      apply(8'b1000_0001, 1'b0, 3'(k));
      chk($sformatf("right_sweep_%0d", k), out, right_exp[k]);
    end
    for (int k = 0; k < 8; k++) begin
      apply(8'b1000_0001, 1'b1, 3'(k));
      chk($sformatf("left_sweep_%0d", k), out, left_exp[k]);
    end

    apply(8'h01, 1'b1, 3'd7); chk("walk_l7", out, 8'h80);
    apply(8'h01, 1'b0, 3'd1); chk("walk_r1", out, 8'h80);
    apply(8'hA5, 1'b0, 3'd0); chk("pass_r0", out, 8'hA5);
    apply(8'hA5, 1'b1, 3'd0); chk("pass_l0", out, 8'hA5);
    apply(8'h01, 1'b1, 3'd1); chk("walk_l1", out, 8'h02);

    // Exhaustive sweep against the model.
    for (int d = 0; d < 256; d++)
      for (int l = 0; l < 2; l++)
        for (int k = 0; k < 8; k++) begin
          apply(8'(d), 1'(l), 3'(k));
          chk($sformatf("exh_%02h_%0d_%0d", d, l, k), out, ref_rot(8'(d), 1'(l), k));
        end

    // Left by k must equal right by (8-k)%8.
    repeat (8) begin
      r = 8'($urandom);
      for (int k = 0; k < 8; k++) begin
        apply(r, 1'b1, 3'(k));
        first = out;
        chk("equiv_left_model", first, ref_rot(r, 1'b1, k));
        k2 = (8 - k) % 8;
        apply(r, 1'b0, 3'(k2));
        chk($sformatf("equiv_%02h_%0d", r, k), out, first);
      end
    end

    // Random stream with reset pulses landing between edges.
    for (int it = 0; it < 300; it++) begin
      in  = 8'($urandom);
      lr  = 1'($urandom);
      sha = 3'($urandom);
      if (it % 23 == 11) begin
        in = in | 8'h01;
        rst = 1'b1;
        #1 chk("rst_mid", out, 8'h00);
        #1 rst = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("rand_%0d", it), out, ref_rot(in, lr, int'(sha)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
